// File: rtl/hdmi_period_sequencer.sv
// rtl/hdmi_period_sequencer.sv - parametrised raster timing and HDMI TMDS period sequencer
// Data-island sequencing is built only when HDMI_DATA_ISLAND_EN is defined (DVI mode otherwise).
module hdmi_period_sequencer #(
   parameter int H_ACTIVE       = 1280,
   parameter int H_FRONT        = 110,
   parameter int H_SYNC         = 40,
   parameter int H_BACK         = 220,
   parameter int V_ACTIVE       = 720,
   parameter int V_FRONT        = 5,
   parameter int V_SYNC         = 5,
   parameter int V_BACK         = 20,
   parameter int HSYNC_POL      = 1,
   parameter int VSYNC_POL      = 1,
   parameter int ISLAND_PACKETS = 1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   input  logic        island_req,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        hsync,
   output logic        vsync,
   output logic [2:0]  period,
   output logic [3:0]  ctl,
   output logic        island_ack,
   output logic [1:0]  island_pkt,
   output logic [4:0]  island_px,
   output logic        line_start,
   output logic        frame_start
);

   typedef enum logic [2:0] {
      P_CTRL    = 3'd0,
      P_VPRE    = 3'd1,
      P_VGUARD  = 3'd2,
      P_VACT    = 3'd3,
      P_DPRE    = 3'd4,
      P_DGUARD  = 3'd5,
      P_DISLAND = 3'd6,
      P_DTGUARD = 3'd7
   } period_t;

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [11:0] VPRE_BEG = 12'(H_TOTAL - 10);
   localparam logic [11:0] VPRE_END = 12'(H_TOTAL - 3);
   localparam logic        HS_ON    = (HSYNC_POL != 0);
   localparam logic        VS_ON    = (VSYNC_POL != 0);

   // The island must fit between the sync start and the video preamble of the same line.
`ifdef HDMI_DATA_ISLAND_EN
   if (H_SYNC + H_BACK < 32 * ISLAND_PACKETS + 28 || ISLAND_PACKETS < 1 || ISLAND_PACKETS > 4) begin : g_bad_timing
      $error("hdmi_period_sequencer: horizontal blanking too short for data island");
   end
`else
   if (H_SYNC + H_BACK < 14 || ISLAND_PACKETS < 1 || ISLAND_PACKETS > 4) begin : g_bad_timing
      $error("hdmi_period_sequencer: horizontal blanking too short for video preamble");
   end
`endif

   logic [11:0] nx, ny, nny;
   period_t     n_period;
   logic [3:0]  n_ctl;
   logic        n_ack;
   logic [1:0]  n_pkt;
   logic [4:0]  n_px;

   assign nx  = (x == H_LAST) ? 12'd0 : x + 12'd1;
   assign ny  = (x == H_LAST) ? ((y == V_LAST) ? 12'd0 : y + 12'd1) : y;
   assign nny = (ny == V_LAST) ? 12'd0 : ny + 12'd1;

`ifdef HDMI_DATA_ISLAND_EN
   localparam logic [11:0] DEC_X    = 12'(H_ACTIVE + H_FRONT - 1);
   localparam logic [11:0] DPRE_END = 12'(H_ACTIVE + H_FRONT + 8);
   localparam logic [11:0] DISL_BEG = 12'(H_ACTIVE + H_FRONT + 10);
   localparam logic [11:0] DTG_BEG  = 12'(H_ACTIVE + H_FRONT + 10 + 32 * ISLAND_PACKETS);
   localparam logic [11:0] ISL_END  = 12'(H_ACTIVE + H_FRONT + 12 + 32 * ISLAND_PACKETS);

   logic        island_run;
   logic        n_run;
   logic [11:0] isl_off;
   logic [4:0]  unused_off_hi;

   // Request is sampled once per line, on the pixel just before sync start.
   assign n_run         = (x == DEC_X) ? island_req : (island_run && nx < ISL_END);
   assign isl_off       = nx - DISL_BEG;
   assign unused_off_hi = isl_off[11:7];

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         island_run <= 1'b0;
      end else if (en) begin
         island_run <= n_run;
      end
   end
`else
   logic unused_req;
   assign unused_req = island_req;
`endif

   always_comb begin
      n_period = P_CTRL;
      n_ctl    = 4'b0000;
      n_ack    = 1'b0;
      n_pkt    = 2'd0;
      n_px     = 5'd0;
      if (nx < H_ACT && ny < V_ACT) begin
         n_period = P_VACT;
      end else if (nny < V_ACT && nx >= VPRE_BEG) begin
         if (nx <= VPRE_END) begin
            n_period = P_VPRE;
            n_ctl    = 4'b0001;
         end else begin
            n_period = P_VGUARD;
         end
      end
`ifdef HDMI_DATA_ISLAND_EN
      else if (n_run) begin
         if (nx < DPRE_END) begin
            n_period = P_DPRE;
            n_ctl    = 4'b0101;
         end else if (nx < DISL_BEG) begin
            n_period = P_DGUARD;
         end else if (nx < DTG_BEG) begin
            n_period = P_DISLAND;
            n_ack    = (nx == DISL_BEG);
            n_pkt    = isl_off[6:5];
            n_px     = isl_off[4:0];
         end else begin
            n_period = P_DTGUARD;
         end
      end
`endif
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         x           <= H_LAST;
         y           <= V_LAST;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         period      <= P_CTRL;
         ctl         <= 4'b0000;
         island_ack  <= 1'b0;
         island_pkt  <= 2'd0;
         island_px   <= 5'd0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         x           <= nx;
         y           <= ny;
         hsync       <= (nx >= HS_BEG && nx < HS_END) ? HS_ON : ~HS_ON;
         vsync       <= (ny >= VS_BEG && ny < VS_END) ? VS_ON : ~VS_ON;
         period      <= n_period;
         ctl         <= n_ctl;
         island_ack  <= n_ack;
         island_pkt  <= n_pkt;
         island_px   <= n_px;
         line_start  <= (nx == 12'd0);
         frame_start <= (nx == 12'd0) && (ny == 12'd0);
      end
   end

endmodule
